// File: rtl/systolic_tile_v2.sv
// Output-stationary ROWS x COLS systolic tile: skewed operand injection, per-PE MAC,
// then a row-by-row result drain over a valid/ready port.
//
// state | meaning
// ACCUM | accepting beats; counts them against the latched signCount
// FLUSH | input closed; waits for the last beat to reach PE(ROWS-1,COLS-1)
// DRAIN | presents accumulator rows 0..ROWS-1 on m_data, then clears
module systolic_tile_v2 #(
  parameter int ROWS   = 8,
  parameter int COLS   = 8,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ROWS*DATA_W-1:0]  activate,
  input  logic [COLS*DATA_W-1:0]  weight,
  input  logic                    vaild,
  output logic                    s_ready,
  input  logic [CNT_W-1:0]        signCount,
  input  logic                    signed_mode,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [COLS*ACC_W-1:0]   m_data,
  output logic                    m_last,
  output logic                    busy
);

  localparam int FL_W = $clog2(ROWS + COLS);
  localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [FL_W-1:0] FL_LOAD  = FL_W'(ROWS + COLS - 1);
  localparam logic [RW-1:0]   ROW_LAST = RW'(ROWS - 1);

  typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
  state_t state, state_nxt;

  logic [CNT_W-1:0] beat_cnt, count_q, count_eff;
  logic             mode_q, mode_eff, first_beat, accept, last_beat, drain_done;
  logic [FL_W-1:0]  flush_cnt;
  logic [RW-1:0]    row;

  logic [DATA_W-1:0] a_pe [ROWS][COLS];
  logic [DATA_W-1:0] w_pe [ROWS][COLS];
  logic              v_pe [ROWS][COLS];
  logic [ACC_W-1:0]  acc  [ROWS][COLS];

  assign s_ready    = (state == ACCUM);
  assign m_valid    = (state == DRAIN);
  assign m_last     = m_valid && (row == ROW_LAST);
  assign busy       = (state != ACCUM) || (beat_cnt != '0);
  assign accept     = vaild && s_ready;
  assign first_beat = (beat_cnt == '0);
  // The first beat of a tile must already see the live signCount/signed_mode.
  assign count_eff  = first_beat ? signCount : count_q;
  assign mode_eff   = (first_beat && s_ready) ? signed_mode : mode_q;
  assign last_beat  = accept && (beat_cnt == count_eff);
  assign drain_done = m_valid && m_ready && (row == ROW_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ACCUM:   if (last_beat) state_nxt = FLUSH;
      FLUSH:   if (flush_cnt == '0) state_nxt = DRAIN;
      DRAIN:   if (drain_done) state_nxt = ACCUM;
      default: state_nxt = ACCUM;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      beat_cnt  <= '0;
      count_q   <= '0;
      mode_q    <= 1'b0;
      flush_cnt <= '0;
      row       <= '0;
    end else begin
      if (last_beat)   beat_cnt <= '0;
      else if (accept) beat_cnt <= beat_cnt + CNT_W'(1);
      if (accept && first_beat) begin
        count_q <= signCount;
        mode_q  <= signed_mode;
      end
      if (last_beat)
        flush_cnt <= FL_LOAD;
      else if (state == FLUSH && flush_cnt != '0)
        flush_cnt <= flush_cnt - FL_W'(1);
      if (drain_done)             row <= '0;
      else if (m_valid && m_ready) row <= row + RW'(1);
    end
  end

  always_comb begin
    m_data = '0;
    if (m_valid)
      for (int j = 0; j < COLS; j++) m_data[j*ACC_W +: ACC_W] = acc[row][j];
  end

  // Activation lane i enters column 0 after i register stages.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_askew
    logic [DATA_W-1:0] a_lane;
    assign a_lane = accept ? activate[gi*DATA_W +: DATA_W] : '0;
    if (gi == 0) begin : g_direct
      assign a_pe[gi][0] = a_lane;
      assign v_pe[gi][0] = accept;
    end else begin : g_delay
      logic [DATA_W-1:0] a_sh [gi];
      logic              v_sh [gi];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < gi; k++) begin
            a_sh[k] <= '0;
            v_sh[k] <= 1'b0;
          end
        end else begin
          a_sh[0] <= a_lane;
          v_sh[0] <= accept;
          for (int k = 1; k < gi; k++) begin
            a_sh[k] <= a_sh[k-1];
            v_sh[k] <= v_sh[k-1];
          end
        end
      end
      assign a_pe[gi][0] = a_sh[gi-1];
      assign v_pe[gi][0] = v_sh[gi-1];
    end
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_wskew
    logic [DATA_W-1:0] w_lane;
    assign w_lane = accept ? weight[gj*DATA_W +: DATA_W] : '0;
    if (gj == 0) begin : g_direct
      assign w_pe[0][gj] = w_lane;
    end else begin : g_delay
      logic [DATA_W-1:0] w_sh [gj];
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          for (int k = 0; k < gj; k++) w_sh[k] <= '0;
        end else begin
          w_sh[0] <= w_lane;
          for (int k = 1; k < gj; k++) w_sh[k] <= w_sh[k-1];
        end
      end
      assign w_pe[0][gj] = w_sh[gj-1];
    end
  end

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_row
    for (genvar gj = 0; gj < COLS; gj++) begin : g_pe
      logic [DATA_W-1:0]          a_cur, w_cur;
      logic [2*DATA_W-1:0]        prod_u;
      logic signed [2*DATA_W-1:0] prod_s;
      logic [ACC_W-1:0]           prod_ext, acc_q;

      assign a_cur    = a_pe[gi][gj];
      assign w_cur    = w_pe[gi][gj];
      assign prod_u   = {{DATA_W{1'b0}}, a_cur} * {{DATA_W{1'b0}}, w_cur};
      assign prod_s   = $signed({{DATA_W{a_cur[DATA_W-1]}}, a_cur})
                      * $signed({{DATA_W{w_cur[DATA_W-1]}}, w_cur});
      assign prod_ext = mode_eff ? ACC_W'(prod_s) : ACC_W'(prod_u);

      always_ff @(posedge clk or negedge reset) begin
        if (!reset)              acc_q <= '0;
        else if (drain_done)     acc_q <= '0;
        else if (v_pe[gi][gj])   acc_q <= acc_q + prod_ext;
      end
      assign acc[gi][gj] = acc_q;

      if (gj < COLS - 1) begin : g_a_fwd
        logic [DATA_W-1:0] a_q;
        logic              v_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) begin
            a_q <= '0;
            v_q <= 1'b0;
          end else begin
            a_q <= a_cur;
            v_q <= v_pe[gi][gj];
          end
        end
        assign a_pe[gi][gj+1] = a_q;
        assign v_pe[gi][gj+1] = v_q;
      end

      if (gi < ROWS - 1) begin : g_w_fwd
        logic [DATA_W-1:0] w_q;
        always_ff @(posedge clk or negedge reset) begin
          if (!reset) w_q <= '0;
          else        w_q <= w_cur;
        end
        assign w_pe[gi+1][gj] = w_q;
      end
    end
  end

endmodule

// File: tb/tb_systolic_tile_v2.sv
// Self-checking bench for systolic_tile_v2: a default 32-bit instance and a 16-bit-accumulator
// instance share stimulus; results are compared against a sum-of-products model.
module tb_systolic_tile_v2;
  localparam int ROWS = 8, COLS = 8, DW = 8, CNT_W = 16;

  logic clk = 1'b0;
  logic reset;
  logic [ROWS*DW-1:0] activate;
  logic [COLS*DW-1:0] weight;
  logic vaild, m_ready, signed_mode;
  logic [CNT_W-1:0] signCount;
  logic s_ready, m_valid, m_last, busy;
  logic [COLS*32-1:0] m_data;
  logic s_ready16, m_valid16, m_last16, busy16;
  logic [COLS*16-1:0] m_data16;

  systolic_tile_v2 dut (
    .clk(clk), .reset(reset), .activate(activate), .weight(weight), .vaild(vaild),
    .s_ready(s_ready), .signCount(signCount), .signed_mode(signed_mode), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy));

  systolic_tile_v2 #(.ACC_W(16)) dut16 (
    .clk(clk), .reset(reset), .activate(activate), .weight(weight), .vaild(vaild),
    .s_ready(s_ready16), .signCount(signCount), .signed_mode(signed_mode), .m_valid(m_valid16),
    .m_ready(m_ready), .m_data(m_data16), .m_last(m_last16), .busy(busy16));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;
  int act_b [16][ROWS];
  int wt_b  [16][COLS];
  logic [COLS*32-1:0] exp32 [ROWS];
  logic [COLS*16-1:0] exp16 [ROWS];
  logic [COLS*32-1:0] got32 [ROWS];
  logic [COLS*16-1:0] got16 [ROWS];
  logic [ROWS-1:0]    got_last;
  int lat;
  bit send_to, timeout, hold_bad, sready_bad, sync_bad;

  // Result block = sum over beats of the outer product, wrapped to the accumulator width.
  function automatic void build_expected(input int n, input bit smode);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        longint s = 0;
        for (int b = 0; b < n; b++) begin
          longint a = act_b[b][r];
          longint w = wt_b[b][c];
          if (smode && a > 127) a -= 256;
          if (smode && w > 127) w -= 256;
          s += a * w;
        end
        exp32[r][c*32 +: 32] = s[31:0];
        exp16[r][c*16 +: 16] = s[15:0];
      end
  endfunction

  function automatic void fill_const(input int n, input int a, input int w);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ROWS; i++) act_b[b][i] = a;
      for (int j = 0; j < COLS; j++) wt_b[b][j] = w;
    end
  endfunction

  function automatic void fill_random(input int n);
    for (int b = 0; b < n; b++) begin
      for (int i = 0; i < ROWS; i++) act_b[b][i] = int'($urandom_range(0, 255));
      for (int j = 0; j < COLS; j++) wt_b[b][j] = int'($urandom_range(0, 255));
    end
  endfunction

  // After the first beat, signCount and signed_mode are scrambled; the tile must ignore them.
  task automatic send_tile(input int n, input bit smode, input int max_gap);
    int guard;
    send_to = 1'b0;
    for (int b = 0; b < n; b++) begin
      if (b > 0 && max_gap > 0)
        repeat ($urandom_range(0, max_gap)) begin
          @(negedge clk);
          vaild = 1'b0;
        end
      @(negedge clk);
      for (int i = 0; i < ROWS; i++) activate[i*DW +: DW] = DW'(act_b[b][i]);
      for (int j = 0; j < COLS; j++) weight[j*DW +: DW] = DW'(wt_b[b][j]);
      vaild       = 1'b1;
      signCount   = (b == 0) ? CNT_W'(n - 1) : CNT_W'($urandom);
      signed_mode = (b == 0) ? smode : ~smode;
      guard = 0;
      while (!s_ready && guard < 50) begin
        @(negedge clk);
        guard++;
      end
      if (guard >= 50) send_to = 1'b1;
    end
    @(negedge clk);
    vaild       = 1'b0;
    signCount   = CNT_W'($urandom);
    signed_mode = 1'($urandom);
  endtask

  // Called on the negedge right after the last beat's accepting edge.
  task automatic collect(input int nrows, input int hold_row);
    timeout = 1'b0; hold_bad = 1'b0; sready_bad = 1'b0; sync_bad = 1'b0;
    got_last = '0;
    lat = 0;
    while (!m_valid && lat < 100) begin
      if (s_ready) sready_bad = 1'b1;
      @(negedge clk);
      lat++;
    end
    for (int r = 0; r < nrows; r++) begin
      if (!m_valid) begin
        timeout = 1'b1;
        return;
      end
      got32[r] = m_data;
      got16[r] = m_data16;
      got_last[r] = m_last;
      if (s_ready) sready_bad = 1'b1;
      if (m_valid16 !== m_valid || m_last16 !== m_last || s_ready16 !== s_ready) sync_bad = 1'b1;
      if (r == hold_row) begin
        m_ready = 1'b0;
        vaild = 1'b1;
        activate = {$urandom, $urandom};
        weight = {$urandom, $urandom};
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          if (m_data !== got32[r] || m_last !== got_last[r] || m_valid !== 1'b1 || s_ready)
            hold_bad = 1'b1;
        end
        vaild = 1'b0;
      end
      m_ready = 1'b1;
      @(negedge clk);
      m_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({m_valid, m_last, busy, m_data} !== '0 || {m_valid16, m_last16, busy16, m_data16} !== '0)
      $display("FAIL reset_outputs got valid=%b last=%b busy=%b data=%h required all zero",
               m_valid, m_last, busy, m_data);
    else passes++;
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (s_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_release got s_ready=%b busy=%b required 1 0", s_ready, busy);
    else passes++;
  endtask

  task automatic test_uniform();
    fill_const(4, 1, 2);
    build_expected(4, 1'($urandom));
    send_tile(4, 1'b0, 0);
    collect(ROWS, -1);
    checks++;
    if (send_to || timeout || lat !== 16)
      $display("FAIL uniform_latency got %0d (timeout=%b) required 16", lat, timeout || send_to);
    else passes++;
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (got32[r] !== exp32[r] || got16[r] !== exp16[r] || got32[r][31:0] !== 32'd8)
        $display("FAIL uniform_row%0d got %h / %h required %h / %h", r, got32[r], got16[r], exp32[r], exp16[r]);
      else passes++;
    end
    checks++;
    if (got_last !== 8'h80 || sready_bad || sync_bad)
      $display("FAIL uniform_flags got last=%b sready_bad=%b sync_bad=%b required 10000000 0 0",
               got_last, sready_bad, sync_bad);
    else passes++;
    checks++;
    if (m_valid !== 1'b0 || s_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL uniform_post got valid=%b s_ready=%b busy=%b required 0 1 0", m_valid, s_ready, busy);
    else passes++;
  endtask

  task automatic test_outer();
    for (int i = 0; i < ROWS; i++) act_b[0][i] = i + 1;
    for (int j = 0; j < COLS; j++) wt_b[0][j] = j + 1;
    build_expected(1, 1'b0);
    send_tile(1, 1'b0, 0);
    collect(ROWS, -1);
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (timeout || got32[r] !== exp32[r] || got16[r] !== exp16[r])
        $display("FAIL outer_row%0d got %h required %h", r, got32[r], exp32[r]);
      else passes++;
    end
    checks++;
    if (got32[7][7*32 +: 32] !== 32'd64 || lat !== 16)
      $display("FAIL outer_r7c7 got %0d lat %0d required 64 lat 16", got32[7][7*32 +: 32], lat);
    else passes++;
  endtask

  task automatic test_mode();
    logic [31:0] req [3];
    req[0] = 32'hFFFFFFFD; req[1] = 32'd765; req[2] = 32'hFFFFFFFA;
    for (int t = 0; t < 3; t++) begin
      int n = (t == 2) ? 2 : 1;
      bit sm = (t != 1);
      fill_const(n, 8'hFF, 8'h03);
      build_expected(n, sm);
      send_tile(n, sm, 0);
      collect(ROWS, -1);
      checks++;
      if (timeout || got32[0][31:0] !== req[t] || got32[ROWS-1][(COLS-1)*32 +: 32] !== req[t])
        $display("FAIL mode_case%0d got %h required %h", t, got32[0][31:0], req[t]);
      else passes++;
      checks++;
      if (got32[3] !== exp32[3] || got16[5] !== exp16[5])
        $display("FAIL mode_case%0d_rows got %h required %h", t, got32[3], exp32[3]);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    int n = int'($urandom_range(1, 5));
    fill_random(n);
    build_expected(n, 1'b1);
    send_tile(n, 1'b1, 0);
    collect(ROWS, 3);
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (timeout || got32[r] !== exp32[r] || got16[r] !== exp16[r])
        $display("FAIL bp_row%0d got %h required %h", r, got32[r], exp32[r]);
      else passes++;
    end
    checks++;
    if (hold_bad || got_last !== 8'h80 || busy !== 1'b0)
      $display("FAIL bp_hold got hold_bad=%b last=%b busy=%b required 0 10000000 0", hold_bad, got_last, busy);
    else passes++;
  endtask

  task automatic test_back_to_back(input int tiles, input int max_gap);
    for (int t = 0; t < tiles; t++) begin
      int n = int'($urandom_range(1, 8));
      bit sm = 1'($urandom);
      fill_random(n);
      build_expected(n, sm);
      send_tile(n, sm, max_gap);
      collect(ROWS, (t % 2 == 1) ? int'($urandom_range(0, ROWS - 1)) : -1);
      checks++;
      if (send_to || timeout || lat !== 16 || sync_bad || hold_bad)
        $display("FAIL b2b_tile%0d_timing got lat=%0d timeout=%b sync=%b hold=%b required 16 0 0 0",
                 t, lat, timeout || send_to, sync_bad, hold_bad);
      else passes++;
      for (int r = 0; r < ROWS; r++) begin
        checks++;
        if (got32[r] !== exp32[r] || got16[r] !== exp16[r])
          $display("FAIL b2b_tile%0d_row%0d got %h / %h required %h / %h", t, r, got32[r], got16[r], exp32[r], exp16[r]);
        else passes++;
      end
    end
  endtask

  task automatic test_overflow();
    fill_const(2, 8'hFF, 8'hFF);
    build_expected(2, 1'b0);
    send_tile(2, 1'b0, 0);
    collect(ROWS, -1);
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (timeout || got16[r] !== exp16[r] || got32[r] !== exp32[r])
        $display("FAIL overflow_row%0d got %h required %h", r, got16[r], exp16[r]);
      else passes++;
    end
    checks++;
    if (got16[2][3*16 +: 16] !== 16'd64514 || got32[2][3*32 +: 32] !== 32'd130050)
      $display("FAIL overflow_word got %0d / %0d required 64514 / 130050",
               got16[2][3*16 +: 16], got32[2][3*32 +: 32]);
    else passes++;
  endtask

  task automatic test_reset_mid_drain();
    fill_const(4, 1, 2);
    send_tile(4, 1'b0, 0);
    collect(4, -1);
    checks++;
    if (timeout || m_valid !== 1'b1)
      $display("FAIL middrain_pre got valid=%b timeout=%b required 1 0", m_valid, timeout);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || busy !== 1'b0 || m_data !== '0 || m_valid16 !== 1'b0)
      $display("FAIL middrain_reset got valid=%b last=%b busy=%b required 0 0 0", m_valid, m_last, busy);
    else passes++;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy16 !== 1'b0)
      $display("FAIL middrain_busy got %b required 0", busy);
    else passes++;
    reset = 1'b1;
    build_expected(4, 1'b0);
    send_tile(4, 1'b0, 0);
    collect(ROWS, -1);
    for (int r = 0; r < ROWS; r++) begin
      checks++;
      if (timeout || got32[r] !== exp32[r] || got32[r][COLS*32-1 -: 32] !== 32'd8)
        $display("FAIL middrain_after_row%0d got %h required %h", r, got32[r], exp32[r]);
      else passes++;
    end
  endtask

  initial begin
    vaild = 1'b0; m_ready = 1'b0; signed_mode = 1'b0; signCount = '0;
    activate = '0; weight = '0;
    test_reset();
    test_uniform();
    test_outer();
    test_mode();
    test_backpressure();
    test_back_to_back(2, 0);
    test_overflow();
    test_reset_mid_drain();
    test_back_to_back(6, 3);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got no finish required finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
